// File: rtl/ahb_wdata_encoder_if.sv
// Write-data bus bundle between the master core and the HWDATA encoder stage.
// The encoder owns the slave modport; the core (or its model) drives via the master modport.
interface ahb_wdata_encoder_if #(
  parameter int CNT_W = 16
) ();
  logic [31:0]      wdata_in;
  logic             wdata_valid;
  logic             HREADY;
  logic             enc_en;
  logic [33:0]      HWDATA;
  logic [1:0]       enc_mode;
  logic [CNT_W-1:0] toggle_cnt;
  logic             busy;

  modport slave (
    input  wdata_in,
    input  wdata_valid,
    input  HREADY,
    input  enc_en,
    output HWDATA,
    output enc_mode,
    output toggle_cnt,
    output busy
  );

  modport master (
    output wdata_in,
    output wdata_valid,
    output HREADY,
    output enc_en,
    input  HWDATA,
    input  enc_mode,
    input  toggle_cnt,
    input  busy
  );
endinterface

// File: rtl/ahb_wdata_encoder.sv
// Master-side HWDATA stage: per accepted beat, picks the reversible payload encoding
// that toggles the fewest of the 34 driven bits, and keeps a saturating toggle tally.
module ahb_wdata_encoder #(
  parameter int         CNT_W      = 16,
  parameter logic [1:0] FIXED_MODE = 2'b00
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  ahb_wdata_encoder_if.slave   bus
);

  localparam logic [1:0] M_INV  = 2'b00;
  localparam logic [1:0] M_SWAP = 2'b01;
  localparam logic [1:0] M_IEVN = 2'b10;
  localparam logic [1:0] M_IODD = 2'b11;

  logic [33:0]      hwdata_q, hwdata_d;
  logic [CNT_W-1:0] toggle_cnt_q, toggle_cnt_d;
  logic             busy_q, busy_d;

  logic [33:0]      cand   [4];
  logic [5:0]       cost   [4];
  logic [1:0]       best_mode;
  logic [1:0]       sel_mode;
  logic [CNT_W:0]   cnt_sum;
  logic             load;

  function automatic logic [31:0] encode(input logic [31:0] d, input logic [1:0] m);
    logic [31:0] p;
    p = ~d;
    case (m)
      M_INV:  p = ~d;
      M_SWAP: p = ({d[30:0], 1'b0} & 32'hAAAA_AAAA) | ({1'b0, d[31:1]} & 32'h5555_5555);
      M_IEVN: p = d ^ 32'h5555_5555;
      M_IODD: p = d ^ 32'hAAAA_AAAA;
      default: p = ~d;
    endcase
    return p;
  endfunction

  function automatic logic [5:0] popcount34(input logic [33:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 34; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

  // Costs are taken against what is on the wires now, so back-to-back beats chain correctly.
  always_comb begin
    for (int m = 0; m < 4; m++) begin
      cand[m] = {encode(bus.wdata_in, 2'(m)), 2'(m)};
      cost[m] = popcount34(cand[m] ^ hwdata_q);
    end
  end

  // Strict less-than in priority order gives ties to Swap, then InvEven, InvOdd, Invert.
  always_comb begin
    best_mode = M_SWAP;
    if (cost[M_IEVN] < cost[best_mode]) best_mode = M_IEVN;
    if (cost[M_IODD] < cost[best_mode]) best_mode = M_IODD;
    if (cost[M_INV]  < cost[best_mode]) best_mode = M_INV;
  end

  assign sel_mode = bus.enc_en ? best_mode : FIXED_MODE;
  assign load     = bus.wdata_valid & bus.HREADY;
  assign cnt_sum  = {1'b0, toggle_cnt_q} + (CNT_W+1)'(cost[sel_mode]);

  always_comb begin
    hwdata_d     = hwdata_q;
    toggle_cnt_d = toggle_cnt_q;
    busy_d       = busy_q;
    if (load) begin
      hwdata_d     = cand[sel_mode];
      toggle_cnt_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
      busy_d       = 1'b1;
    end else if (bus.HREADY) begin
      busy_d       = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hwdata_q     <= 34'h0;
      toggle_cnt_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      hwdata_q     <= hwdata_d;
      toggle_cnt_q <= toggle_cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.HWDATA     = hwdata_q;
  assign bus.enc_mode   = hwdata_q[1:0];
  assign bus.toggle_cnt = toggle_cnt_q;
  assign bus.busy       = busy_q;

endmodule

// File: doc/ahb_wdata_encoder.md
Name: ahb_wdata_encoder

Overview:
- Master-side write-data stage that drives the 34-bit encoded HWDATA bus consumed by the AHB slave decoder.
- Per accepted write beat, picks one of four reversible encodings of the 32-bit payload that minimises bit toggles against the word last driven on HWDATA.
- Drives HWDATA = {payload[31:0], mode[1:0]} in the data phase, holding it through wait states.

Parameters:
- CNT_W, 16, width of saturating toggle statistics counter.
- FIXED_MODE, 2'b00, mode used when enc_en is low.

Ports:
- HCLK  in  1  bus clock; all state on posedge.
- HRESETn  in  1  reset, asynchronous, active-low.
- wdata_in  in  32  raw write data from master core, valid with wdata_valid.
- wdata_valid  in  1  write beat accepted this cycle (address phase: HWRITE & HTRANS NONSEQ/SEQ & HREADY).
- HREADY  in  1  bus ready; low = current data phase extended.
- enc_en  in  1  1 = adaptive selection; 0 = always FIXED_MODE.
- HWDATA  out  34  [33:2] encoded payload, [1:0] mode.
- enc_mode  out  2  mode currently driven (copy of HWDATA[1:0]).
- toggle_cnt  out  CNT_W  saturating sum of HWDATA bit toggles since reset.
- busy  out  1  high while a driven beat awaits HREADY.

Behaviour:
- Encodings (decoder-exact), d = wdata_in, p = payload:
  - 00 Invert: p = ~d.
  - 01 Swap: p[2k+1] = d[2k], p[2k] = d[2k+1], for k = 0..15.
  - 10 InvEven: p[k] = ~d[k] for even k; odd bits pass.
  - 11 InvOdd: p[k] = ~d[k] for odd k; even bits pass.
- Cost:
  - cost(m) = popcount({p_m, m} ^ HWDATA), over all 34 bits including the mode bits.
  - Select minimum cost. Tie priority 01 > 10 > 11 > 00 (lowest mode code wins, except Invert last).
  - enc_en = 0: mode = FIXED_MODE; cost is still used for toggle_cnt.
- Load condition: wdata_valid & HREADY at posedge.
  - HWDATA <= selected word.
  - toggle_cnt += cost(selected), saturating at all-ones.
  - busy <= 1.
- Latency: exactly 1 cycle. Data is sampled in the address-phase cycle and appears on HWDATA for the following data phase.
- HREADY low: HWDATA, enc_mode, toggle_cnt frozen; wdata_valid ignored. busy stays 1.
- HREADY high & !wdata_valid: HWDATA holds its last value (no idle toggles); busy <= 0.
- Back-to-back beats (wdata_valid every cycle, HREADY high): a new word each cycle. Each cost is computed against the word driven in the immediately preceding cycle.
- Reset (async, any time including mid-burst): HWDATA = 34'h0, enc_mode = 2'b00, toggle_cnt = 0, busy = 0. The first beat after reset is compared against 34'h0.
- toggle_cnt at saturation: stays all-ones; no wrap.
- Cost/selection is combinational from wdata_in and the HWDATA register; only the output is registered.

Test Plan:
- Reset, wdata_in = 32'hFFFF_FFFF, valid, HREADY = 1 -> next cycle HWDATA = 34'h0, enc_mode = 00, toggle_cnt = 0.
- From reset, wdata_in = 32'h0000_0000 -> modes 00/01/10/11 cost 32/1/17/18. HWDATA = 34'h0_0000_0001, enc_mode = 01, toggle_cnt = 1.
- From reset, wdata_in = 32'h5555_5555 -> mode 10 wins with cost 1. HWDATA = 34'h0_0000_0002, toggle_cnt = 1.
- Tie: from reset, wdata_in = 32'h0000_5555 -> modes 01 and 10 both cost 9. Mode 01 chosen, HWDATA = 34'h0_0002_AAA9, toggle_cnt = 9.
- Stall: load beat, hold HREADY = 0 for 3 cycles while changing wdata_in and asserting valid -> HWDATA and toggle_cnt unchanged, busy = 1. On HREADY = 1 with valid, the new word loads. Then drop valid -> busy = 0 and HWDATA holds.
- enc_en = 0, FIXED_MODE = 00, wdata_in = 32'h1234_5678 -> HWDATA = {32'hEDCB_A987, 2'b00}. Assert HRESETn low mid-burst -> all outputs zero immediately, asynchronously.
